// File: rtl/shift_barrelfast_sright_pipe_if.sv
// Producer/consumer bundle for the pipelined right barrel shifter.
// The slave modport is the shifter; the master modport is the surrounding logic.
interface shift_barrelfast_sright_pipe_if #(
    parameter int unsigned Bits = 64
);
    localparam int unsigned L = $clog2(Bits);

    logic            inp_valid;
    logic            inp_retry;
    logic [Bits-1:0] inp_a;
    logic [L-1:0]    inp_sh;
    logic            inp_arith;
    logic            out_valid;
    logic            out_retry;
    logic [Bits-1:0] out_b;

    modport slave (
        input  inp_valid, inp_a, inp_sh, inp_arith, out_retry,
        output inp_retry, out_valid, out_b
    );

    modport master (
        output inp_valid, inp_a, inp_sh, inp_arith, out_retry,
        input  inp_retry, out_valid, out_b
    );
endinterface

// File: rtl/shift_barrelfast_sright_pipe.sv
// Two-stage right barrel shifter (logical/arithmetic) with valid/retry flow control.
// Stage 1 applies the coarse shift (upper shift bits), stage 2 the fine shift.
module shift_barrelfast_sright_pipe #(
    parameter int unsigned Bits = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    shift_barrelfast_sright_pipe_if.slave   bus
);
    localparam int unsigned L  = $clog2(Bits);
    localparam int unsigned H  = L / 2;
    localparam int unsigned HL = L - H;

    logic            s1_valid_q, s1_valid_d;
    logic [Bits-1:0] s1_data_q,  s1_data_d;
    logic [H-1:0]    s1_shlo_q,  s1_shlo_d;
    logic            s1_arith_q, s1_arith_d;
    logic            s1_sign_q,  s1_sign_d;
    logic            s2_valid_q, s2_valid_d;
    logic [Bits-1:0] s2_data_q,  s2_data_d;

    logic            s1_adv;
    logic            s2_adv;
    logic            fill1;
    logic            fill2;
    logic [L-1:0]    amt1;
    logic [H-1:0]    amt2;

    // Back-pressure: a stage advances when it is empty or its successor advances.
    assign s2_adv        = !s2_valid_q || !bus.out_retry;
    assign s1_adv        = !s1_valid_q || s2_adv;
    assign bus.inp_retry = !s1_adv || reset;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_b     = s2_data_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_shlo_d  = s1_shlo_q;
        s1_arith_d = s1_arith_q;
        s1_sign_d  = s1_sign_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        fill1      = bus.inp_arith & bus.inp_a[Bits-1];
        fill2      = s1_arith_q & s1_sign_q;
        amt1       = {bus.inp_sh[L-1:H], H'(0)};
        amt2       = s1_shlo_q;

        if (s1_adv) begin
            s1_valid_d = bus.inp_valid;
            // Vacated upper bits are forced to the fill value by masking.
            s1_data_d  = (bus.inp_a >> amt1)
                       | (fill1 ? ~({Bits{1'b1}} >> amt1) : {Bits{1'b0}});
            s1_shlo_d  = bus.inp_sh[H-1:0];
            s1_arith_d = bus.inp_arith;
            s1_sign_d  = bus.inp_a[Bits-1];
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = (s1_data_q >> amt2)
                       | (fill2 ? ~({Bits{1'b1}} >> amt2) : {Bits{1'b0}});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_shlo_q  <= '0;
            s1_arith_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_shlo_q  <= s1_shlo_d;
            s1_arith_q <= s1_arith_d;
            s1_sign_q  <= s1_sign_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    // Only the upper shift bits feed stage 1; HL is kept for readability of the split.
    if (HL == 0) begin : g_bad_width
        $error("Bits too small");
    end
endmodule

// File: tb/tb_shift_barrelfast_sright_pipe.sv
// Bench for the pipelined right barrel shifter: 8-bit directed tests and a 64-bit random run.
module tb_shift_barrelfast_sright_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_barrelfast_sright_pipe_if #(.Bits(8))  if8();
    shift_barrelfast_sright_pipe_if #(.Bits(64)) if64();

    shift_barrelfast_sright_pipe #(.Bits(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));
    shift_barrelfast_sright_pipe #(.Bits(64)) dut64 (.clk(clk), .reset(reset), .bus(if64));

    typedef struct {
        logic [7:0] a;
        logic [2:0] sh;
        logic       arith;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[10];
    int         checks = 0;
    int         errors = 0;
    logic [7:0]  q8[$];
    logic [63:0] q64[$];
    int         in64_cnt = 0;
    int         out64_cnt = 0;
    logic       acc64 = 1'b0;

    function automatic logic [7:0] model8(logic [7:0] a, logic [2:0] sh, logic arith);
        logic signed [7:0] sa;
        logic [7:0]        r;
        sa = a;
        if (arith) r = sa >>> sh;
        else       r = a >> sh;
        return r;
    endfunction

    function automatic logic [63:0] model64(logic [63:0] a, logic [5:0] sh, logic arith);
        logic signed [63:0] sa;
        logic [63:0]        r;
        sa = a;
        if (arith) r = sa >>> sh;
        else       r = a >> sh;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(logic [7:0] a, logic [2:0] sh, logic arith);
        if8.inp_valid = 1'b1;
        if8.inp_a     = a;
        if8.inp_sh    = sh;
        if8.inp_arith = arith;
    endtask

    // Scoreboards: output side is consumed before input side so a reset flush keeps order right.
    always @(negedge clk) begin
        if (if8.out_valid === 1'b1 && if8.out_retry === 1'b0) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb8_unexpected: got %0h expected no beat", if8.out_b);
            end else begin
                check("sb8_data", 64'(if8.out_b), 64'(q8.pop_front()));
            end
        end
        if (reset) q8.delete();
        else if (if8.inp_valid && !if8.inp_retry)
            q8.push_back(model8(if8.inp_a, if8.inp_sh, if8.inp_arith));
    end

    always @(negedge clk) begin
        if (if64.out_valid === 1'b1 && if64.out_retry === 1'b0) begin
            out64_cnt++;
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb64_unexpected: got %0h expected no beat", if64.out_b);
            end else begin
                check("sb64_data", if64.out_b, q64.pop_front());
            end
        end
        acc64 = if64.inp_valid && !if64.inp_retry && !reset;
        if (reset) q64.delete();
        else if (acc64) begin
            in64_cnt++;
            q64.push_back(model64(if64.inp_a, if64.inp_sh, if64.inp_arith));
        end
    end

    initial begin
        logic [7:0] hold_b;
        int         bad_v;
        int         bad_r;
        int         stale;
        int         cyc;

        vecs[0] = '{8'hB4, 3'd3, 1'b0, 8'h16};
        vecs[1] = '{8'hB4, 3'd3, 1'b1, 8'hF6};
        vecs[2] = '{8'h5A, 3'd0, 1'b0, 8'h5A};
        vecs[3] = '{8'h80, 3'd7, 1'b1, 8'hFF};
        vecs[4] = '{8'h80, 3'd7, 1'b0, 8'h01};
        vecs[5] = '{8'h7F, 3'd7, 1'b1, 8'h00};
        vecs[6] = '{8'hC3, 3'd4, 1'b1, 8'hFC};
        vecs[7] = '{8'hC3, 3'd4, 1'b0, 8'h0C};
        vecs[8] = '{8'h81, 3'd1, 1'b1, 8'hC0};
        vecs[9] = '{8'h81, 3'd2, 1'b0, 8'h20};

        reset = 1'b1;
        if8.inp_valid  = 1'b0; if8.inp_a  = '0; if8.inp_sh  = '0; if8.inp_arith  = 1'b0;
        if8.out_retry  = 1'b0;
        if64.inp_valid = 1'b0; if64.inp_a = '0; if64.inp_sh = '0; if64.inp_arith = 1'b0;
        if64.out_retry = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_inp_retry", 64'(if8.inp_retry), 64'd1);
        check("rst_out_valid", 64'(if8.out_valid), 64'd0);
        check("rst_out_b",     64'(if8.out_b),     64'd0);
        check("rst64_out_valid", 64'(if64.out_valid), 64'd0);
        reset = 1'b0;
        tick();
        check("idle_inp_retry", 64'(if8.inp_retry), 64'd0);

        // Table vectors, one at a time, with two-cycle latency check
        for (int i = 0; i < 10; i++) begin
            drive8(vecs[i].a, vecs[i].sh, vecs[i].arith);
            tick();
            if8.inp_valid = 1'b0;
            check($sformatf("vec%0d_lat1_valid", i), 64'(if8.out_valid), 64'd0);
            tick();
            check($sformatf("vec%0d_lat2_valid", i), 64'(if8.out_valid), 64'd1);
            check($sformatf("vec%0d_out_b", i), 64'(if8.out_b), 64'(vecs[i].exp));
        end
        tick();

        // Back-to-back stream of 16 beats
        bad_v = 0;
        bad_r = 0;
        for (int i = 0; i < 16; i++) begin
            drive8(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (if8.inp_retry !== 1'b0) bad_r++;
            if (if8.out_valid !== (i >= 2)) bad_v++;
            tick();
        end
        if8.inp_valid = 1'b0;
        if (if8.out_valid !== 1'b1) bad_v++;
        tick();
        if (if8.out_valid !== 1'b1) bad_v++;
        tick();
        if (if8.out_valid !== 1'b0) bad_v++;
        check("stream_inp_retry_cycles", 64'(bad_r), 64'd0);
        check("stream_valid_pattern",    64'(bad_v), 64'd0);
        check("stream_sb_empty",         64'(q8.size()), 64'd0);

        // Fill the pipe with the output stalled for 3 cycles
        if8.out_retry = 1'b1;
        drive8(8'h96, 3'd2, 1'b1);
        check("stall_b0_accept", 64'(if8.inp_retry), 64'd0);
        tick();
        drive8(8'h3C, 3'd5, 1'b0);
        check("stall_b1_accept", 64'(if8.inp_retry), 64'd0);
        tick();
        drive8(8'hE1, 3'd1, 1'b1);
        check("stall_full_retry", 64'(if8.inp_retry), 64'd1);
        check("stall_out_valid",  64'(if8.out_valid), 64'd1);
        check("stall_out_b",      64'(if8.out_b), 64'(model8(8'h96, 3'd2, 1'b1)));
        hold_b = if8.out_b;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("stall_hold%0d_out_b", k), 64'(if8.out_b), 64'(hold_b));
            check($sformatf("stall_hold%0d_valid", k), 64'(if8.out_valid), 64'd1);
            check($sformatf("stall_hold%0d_retry", k), 64'(if8.inp_retry), 64'd1);
        end
        if8.out_retry = 1'b0;
        #1;
        check("stall_release_retry", 64'(if8.inp_retry), 64'd0);
        tick();
        if8.inp_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("stall_drain_empty", 64'(q8.size()), 64'd0);
        check("stall_drain_valid", 64'(if8.out_valid), 64'd0);

        // Reset with two beats in flight
        drive8(8'hF0, 3'd1, 1'b1);
        tick();
        drive8(8'h0F, 3'd2, 1'b0);
        tick();
        if8.inp_valid = 1'b0;
        check("flush_pre_valid", 64'(if8.out_valid), 64'd1);
        if8.out_retry = 1'b1;
        reset = 1'b1;
        tick();
        check("flush_out_valid", 64'(if8.out_valid), 64'd0);
        check("flush_out_b",     64'(if8.out_b),     64'd0);
        check("flush_inp_retry", 64'(if8.inp_retry), 64'd1);
        reset = 1'b0;
        if8.out_retry = 1'b0;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (if8.out_valid !== 1'b0) stale++;
        end
        check("flush_no_stale", 64'(stale), 64'd0);

        // 64-bit random traffic with random stalls
        cyc = 0;
        while (in64_cnt < 10000 && cyc < 60000) begin
            if (!if64.inp_valid || acc64) begin
                if64.inp_valid = ($urandom_range(0, 3) != 0);
                if64.inp_a     = {$urandom, $urandom};
                if64.inp_sh    = 6'($urandom_range(0, 63));
                if64.inp_arith = 1'($urandom_range(0, 1));
            end
            if64.out_retry = ($urandom_range(0, 3) == 0);
            tick();
            cyc++;
        end
        if64.inp_valid = 1'b0;
        if64.out_retry = 1'b0;
        for (int k = 0; k < 10 && q64.size() != 0; k++) tick();
        tick();
        check("rand_beats_in",     64'(in64_cnt >= 10000), 64'd1);
        check("rand_sb_empty",     64'(q64.size()), 64'd0);
        check("rand_beat_count",   64'(out64_cnt), 64'(in64_cnt));
        check("rand_final_valid",  64'(if64.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
